// File: rtl/sm_issue_gate.sv
// -----------------------------------------------------------------------------
// sm_issue_gate
//
// SM-side consumer of the per-SM issue budget. Ready instructions offered by
// the warp schedulers are accumulated in a backlog counter. Every clk_sm cycle
// the gate issues min(backlog, remaining, ISSUE_MAX) instructions (zero while
// en=0) and reports that count combinationally so the adjuster can subtract it
// from its budget in the same cycle.
//
// Ports:
//   clk_sm             SM clock, all state on its rising edge
//   rst_n              asynchronous active-low reset
//   en                 issue enable; 0 holds issue but still accepts requests
//   req_valid          scheduler offers req_count new instructions
//   req_count  [2:0]   number of instructions offered
//   req_ready          gate can accept an offer this cycle
//   remaining  [4:0]   budget left in the current window (from the adjuster)
//   issued_this_cycle [4:0]  instructions issued this cycle (to the adjuster)
//   backlog    [5:0]   registered pending instruction count
//   throttled          last cycle had pending work but zero budget
//   stall_cycles [15:0] saturating count of stalled cycles
//   issued_total [15:0] wrapping count of issued instructions
//   clear_stats        synchronous clear of both statistics counters
//   dbg_state  [1:0]   current FSM state (IDLE=0, ISSUE=1, THROTTLED=2, HOLD=3)
//
// Handshake: an offer is consumed on a rising edge where req_valid && req_ready.
// req_ready is a function of the registered backlog only, so it never depends
// on req_valid or req_count; an offer seen while req_ready=0 is left untouched
// and the scheduler keeps presenting it. req_count=0 with valid is a no-op.
// -----------------------------------------------------------------------------
module sm_issue_gate #(
   parameter int ISSUE_MAX   = 4,
   parameter int BACKLOG_MAX = 32,
   parameter int REQ_MAX     = 7
) (
   input  logic        clk_sm,
   input  logic        rst_n,
   input  logic        en,
   input  logic        req_valid,
   input  logic [2:0]  req_count,
   output logic        req_ready,
   input  logic [4:0]  remaining,
   output logic [4:0]  issued_this_cycle,
   output logic [5:0]  backlog,
   output logic        throttled,
   output logic [15:0] stall_cycles,
   output logic [15:0] issued_total,
   input  logic        clear_stats,
   output logic [1:0]  dbg_state
);

   // Worst-case accept (REQ_MAX) on top of this backlog still fits in
   // BACKLOG_MAX, so the backlog can never overflow.
   localparam logic [5:0] READY_LIMIT = 6'(BACKLOG_MAX - REQ_MAX);
   localparam logic [5:0] ISSUE_CAP   = 6'(ISSUE_MAX);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      THROTTLED = 2'd2,
      HOLD      = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [5:0]  issue_lim;
   logic        accept;
   logic        stall;
   logic [5:0]  backlog_next;

   // ---------------------------------------------------------------------------
   // Issue count: min(backlog, remaining, ISSUE_MAX), gated by en. Because it
   // is bounded by remaining, the adjuster's subtraction cannot underflow.
   // ---------------------------------------------------------------------------
   always_comb begin
      issue_lim = {1'b0, remaining};
      if (backlog < issue_lim) begin
         issue_lim = backlog;
      end
      if (issue_lim > ISSUE_CAP) begin
         issue_lim = ISSUE_CAP;
      end
      issued_this_cycle = en ? issue_lim[4:0] : 5'd0;
   end

   assign req_ready = (backlog <= READY_LIMIT);
   assign accept    = req_valid && req_ready;
   assign stall     = en && (backlog != 6'd0) && (issued_this_cycle == 5'd0);

   // Issue never exceeds backlog, so the subtraction stays non-negative.
   assign backlog_next = backlog - {1'b0, issued_this_cycle}
                       + (accept ? {3'b000, req_count} : 6'd0);

   // ---------------------------------------------------------------------------
   // FSM: next state reflects this cycle's inputs, in priority order.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = IDLE;
      if (!en) begin
         state_next = HOLD;
      end else if (backlog == 6'd0) begin
         state_next = IDLE;
      end else if (remaining == 5'd0) begin
         state_next = THROTTLED;
      end else begin
         state_next = ISSUE;
      end
   end

   always_ff @(posedge clk_sm or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   assign throttled = (state == THROTTLED);
   assign dbg_state = state;

   // ---------------------------------------------------------------------------
   // Backlog register. Reset discards pending work without draining it.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_sm or negedge rst_n) begin
      if (!rst_n) begin
         backlog <= 6'd0;
      end else begin
         backlog <= backlog_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Telemetry counters. clear_stats wins over that edge's increment.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_sm or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= 16'd0;
         issued_total <= 16'd0;
      end else if (clear_stats) begin
         stall_cycles <= 16'd0;
         issued_total <= 16'd0;
      end else begin
         if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         issued_total <= issued_total + {11'd0, issued_this_cycle};
      end
   end

endmodule

// File: tb/tb_sm_issue_gate.sv
// -----------------------------------------------------------------------------
// tb_sm_issue_gate
//
// Directed bench for sm_issue_gate. Inputs change 1 ns after a rising edge and
// outputs are sampled 1 ns after that (well away from the next edge). Expected
// values are worked out by hand in the comments next to each step.
// -----------------------------------------------------------------------------
module tb_sm_issue_gate;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_THROTTLED = 2'd2;
   localparam logic [1:0] S_HOLD      = 2'd3;

   logic        clk_sm;
   logic        rst_n;
   logic        en;
   logic        req_valid;
   logic [2:0]  req_count;
   logic        req_ready;
   logic [4:0]  remaining;
   logic [4:0]  issued_this_cycle;
   logic [5:0]  backlog;
   logic        throttled;
   logic [15:0] stall_cycles;
   logic [15:0] issued_total;
   logic        clear_stats;
   logic [1:0]  dbg_state;

   int vectors;
   int miscompares;

   sm_issue_gate #(
      .ISSUE_MAX   (4),
      .BACKLOG_MAX (32),
      .REQ_MAX     (7)
   ) dut (
      .clk_sm            (clk_sm),
      .rst_n             (rst_n),
      .en                (en),
      .req_valid         (req_valid),
      .req_count         (req_count),
      .req_ready         (req_ready),
      .remaining         (remaining),
      .issued_this_cycle (issued_this_cycle),
      .backlog           (backlog),
      .throttled         (throttled),
      .stall_cycles      (stall_cycles),
      .issued_total      (issued_total),
      .clear_stats       (clear_stats),
      .dbg_state         (dbg_state)
   );

   // clock / reset block
   initial begin
      clk_sm = 1'b0;
      forever #5 clk_sm = ~clk_sm;
   end

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, land 1 ns after it
   task automatic tick();
      @(posedge clk_sm);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      en          = 1'b0;
      req_valid   = 1'b0;
      req_count   = 3'd0;
      remaining   = 5'd0;
      clear_stats = 1'b0;

      // ---- reset state
      #2;
      chk("rst_backlog",  32'(backlog), 32'd0);
      chk("rst_ready",    32'(req_ready), 32'd1);
      chk("rst_throttle", 32'(throttled), 32'd0);
      chk("rst_issued",   32'(issued_this_cycle), 32'd0);
      chk("rst_stall",    32'(stall_cycles), 32'd0);
      chk("rst_total",    32'(issued_total), 32'd0);
      chk("rst_state",    32'(dbg_state), 32'(S_IDLE));
      @(negedge clk_sm);
      rst_n = 1'b1;
      tick();

      // ---- load backlog 10 while held (7 + 3)
      req_valid = 1'b1; req_count = 3'd7;
      tick();
      req_count = 3'd3;
      tick();
      req_valid = 1'b0; req_count = 3'd0;
      chk("load_backlog", 32'(backlog), 32'd10);
      chk("load_state_hold", 32'(dbg_state), 32'(S_HOLD));

      // ---- budget limiting: remaining=3 -> issue 3, backlog 7
      en = 1'b1; remaining = 5'd3;
      #1;
      chk("budget_issue3", 32'(issued_this_cycle), 32'd3);
      tick();
      chk("budget_backlog7", 32'(backlog), 32'd7);
      chk("budget_total3", 32'(issued_total), 32'd3);
      chk("budget_state_issue", 32'(dbg_state), 32'(S_ISSUE));
      // remaining=20 -> capped at ISSUE_MAX=4, backlog 3
      remaining = 5'd20;
      #1;
      chk("cap_issue4", 32'(issued_this_cycle), 32'd4);
      tick();
      chk("cap_backlog3", 32'(backlog), 32'd3);
      chk("cap_total7", 32'(issued_total), 32'd7);

      // ---- throttle: bring backlog to 5 while held, then remaining=0
      en = 1'b0; req_valid = 1'b1; req_count = 3'd2;
      tick();
      req_valid = 1'b0; req_count = 3'd0;
      chk("thr_backlog5", 32'(backlog), 32'd5);
      en = 1'b1; remaining = 5'd0;
      #1;
      chk("thr_issue0", 32'(issued_this_cycle), 32'd0);
      tick();
      chk("thr_flag_e1", 32'(throttled), 32'd1);
      chk("thr_stall_e1", 32'(stall_cycles), 32'd1);
      tick();
      tick();
      chk("thr_issue0_e3", 32'(issued_this_cycle), 32'd0);
      chk("thr_stall3", 32'(stall_cycles), 32'd3);
      chk("thr_backlog_hold", 32'(backlog), 32'd5);
      chk("thr_state", 32'(dbg_state), 32'(S_THROTTLED));

      // ---- reset mid-operation: backlog 10, reset between edges
      en = 1'b0; req_valid = 1'b1; req_count = 3'd5;
      tick();
      req_valid = 1'b0; req_count = 3'd0;
      en = 1'b1; remaining = 5'd20;
      chk("pre_rst_backlog10", 32'(backlog), 32'd10);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_backlog", 32'(backlog), 32'd0);
      chk("mid_rst_issue", 32'(issued_this_cycle), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_throttle", 32'(throttled), 32'd0);
      chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
      chk("mid_rst_total", 32'(issued_total), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_backlog", 32'(backlog), 32'd0);

      // ---- backpressure: 0,7,14,21 accepted -> 28, then not ready
      en = 1'b1; remaining = 5'd0; req_valid = 1'b1; req_count = 3'd7;
      #1;
      chk("bp_ready_at0", 32'(req_ready), 32'd1);
      tick();
      chk("bp_backlog7", 32'(backlog), 32'd7);
      tick();
      tick();
      chk("bp_ready_at21", 32'(req_ready), 32'd1);
      tick();
      chk("bp_backlog28", 32'(backlog), 32'd28);
      chk("bp_not_ready", 32'(req_ready), 32'd0);
      tick();
      tick();
      chk("bp_backlog_hold28", 32'(backlog), 32'd28);
      chk("bp_stall5", 32'(stall_cycles), 32'd5);
      chk("bp_throttled", 32'(throttled), 32'd1);

      // ---- drain 28 -> 4 at 4 per cycle (6 edges, total 24)
      req_valid = 1'b0; req_count = 3'd0; remaining = 5'd20;
      repeat (6) tick();
      chk("drain_backlog4", 32'(backlog), 32'd4);
      chk("drain_total24", 32'(issued_total), 32'd24);
      chk("drain_stall_same", 32'(stall_cycles), 32'd5);

      // ---- simultaneous accept and issue: 4 - 4 + 3 = 3
      req_valid = 1'b1; req_count = 3'd3;
      #1;
      chk("sim_issue4", 32'(issued_this_cycle), 32'd4);
      tick();
      chk("sim_backlog3", 32'(backlog), 32'd3);
      chk("sim_total28", 32'(issued_total), 32'd28);

      // ---- hold: backlog 6, en=0, remaining=20
      en = 1'b0; req_valid = 1'b1; req_count = 3'd3;
      tick();
      req_valid = 1'b0; req_count = 3'd0;
      chk("hold_backlog6", 32'(backlog), 32'd6);
      #1;
      chk("hold_issue0", 32'(issued_this_cycle), 32'd0);
      tick();
      chk("hold_state", 32'(dbg_state), 32'(S_HOLD));
      chk("hold_stall_same", 32'(stall_cycles), 32'd5);
      chk("hold_backlog_same", 32'(backlog), 32'd6);
      chk("hold_total_same", 32'(issued_total), 32'd28);

      // ---- stall saturation: 5 + 65529 = 0xFFFE, then 3 more -> 0xFFFF
      en = 1'b1; remaining = 5'd0;
      repeat (65529) tick();
      chk("sat_fffe", 32'(stall_cycles), 32'hFFFE);
      repeat (3) tick();
      chk("sat_ffff", 32'(stall_cycles), 32'hFFFF);
      chk("sat_backlog6", 32'(backlog), 32'd6);

      // ---- clear_stats on a stall edge wins over the increment
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      chk("clr_stall0", 32'(stall_cycles), 32'd0);
      chk("clr_total0", 32'(issued_total), 32'd0);
      tick();
      chk("clr_stall_resume", 32'(stall_cycles), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
